// File: rtl/dump_pkg.sv
// Shared definitions for the post-halt state dump engine.
package dump_pkg;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REG_RD  = 3'd1,
        ST_MEM_RD  = 3'd2,
        ST_MEM_LAT = 3'd3,
        ST_OUT     = 3'd4,
        ST_DONE    = 3'd5
    } dump_state_t;

    // Beat kind tags.
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Ceiling log2 with a floor of 1 bit, used for the register index width.
    function automatic int unsigned dump_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        if (w == 0) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/dump_beat_reg.sv
// Valid/ready holding register for one dump beat {kind, idx, last, data}.
module dump_beat_reg
    import dump_pkg::*;
#(
    parameter int W_OPR = 32,
    parameter int IW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_kind,
    input  logic [IW-1:0]    i_idx,
    input  logic             i_last,
    input  logic [W_OPR-1:0] i_data,
    input  logic             i_ready,
    output logic             o_accept,
    output logic             o_valid,
    output logic             o_kind,
    output logic [IW-1:0]    o_idx,
    output logic             o_last,
    output logic [W_OPR-1:0] o_data
);

    logic             r_valid;
    logic             r_kind;
    logic [IW-1:0]    r_idx;
    logic             r_last;
    logic [W_OPR-1:0] r_data;

    assign o_accept = r_valid & i_ready;
    assign o_valid  = r_valid;
    assign o_kind   = r_kind;
    assign o_idx    = r_idx;
    assign o_last   = r_last;
    assign o_data   = r_data;

    // Load a new beat, or retire the held one when the sink accepts it.
    // Fields are left untouched on accept; only valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_kind  <= KIND_REG;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_kind  <= i_kind;
            r_idx   <= i_idx;
            r_last  <= i_last;
            r_data  <= i_data;
        end else if (o_accept) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dump_unit.sv
// Post-halt dump engine: walks the register file, then a window of data
// memory, emitting each word as a tagged valid/ready beat.
module dump_unit
    import dump_pkg::*;
#(
    parameter int W_OPR     = 32,
    parameter int N_REG     = 16,
    parameter int ADDR      = 8,
    parameter int MEM_BASE  = 0,
    parameter int MEM_COUNT = 256,
    parameter int IW        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hlt_i,
    output logic [dump_clog2(N_REG)-1:0]  reg_addr_o,
    input  logic [W_OPR-1:0]              reg_data_i,
    output logic                          mem_req_o,
    output logic [ADDR-1:0]               mem_addr_o,
    input  logic [W_OPR-1:0]              mem_data_i,
    output logic                          dump_valid_o,
    input  logic                          dump_ready_i,
    output logic [W_OPR-1:0]              dump_data_o,
    output logic                          dump_kind_o,
    output logic [IW-1:0]                 dump_idx_o,
    output logic                          dump_last_o,
    output logic                          done_o
);

    localparam int unsigned     RW       = dump_clog2(N_REG);
    localparam logic [ADDR-1:0] BASE_A   = ADDR'(MEM_BASE);
    localparam logic [IW-1:0]   LAST_REG = IW'(N_REG - 1);
    localparam logic [IW-1:0]   LAST_MEM = IW'(MEM_COUNT - 1);

    dump_state_t      r_state;
    logic [IW-1:0]    r_idx;
    logic [RW-1:0]    r_reg_addr;
    logic [ADDR-1:0]  r_mem_addr;
    logic             r_mem_req;
    logic             r_done;

    logic             w_load;
    logic             w_kind;
    logic             w_last;
    logic [W_OPR-1:0] w_data;
    logic             w_accept;
    logic             w_beat_kind;
    logic [IW-1:0]    w_beat_idx;
    logic [IW-1:0]    w_idx_inc;
    logic             w_last_reg_beat;
    logic             w_last_mem_beat;

    assign reg_addr_o = r_reg_addr;
    assign mem_addr_o = r_mem_addr;
    assign mem_req_o  = r_mem_req;
    assign done_o     = r_done;

    assign w_idx_inc       = r_idx + IW'(1);
    assign w_last_reg_beat = (w_beat_kind == KIND_REG) && (w_beat_idx == LAST_REG);
    assign w_last_mem_beat = (w_beat_kind == KIND_MEM) && (w_beat_idx == LAST_MEM);

    // Capture strobe and payload for the beat register.
    always_comb begin
        w_load = 1'b0;
        w_kind = KIND_REG;
        w_last = 1'b0;
        w_data = reg_data_i;
        if (r_state == ST_REG_RD) begin
            w_load = 1'b1;
        end else if (r_state == ST_MEM_LAT) begin
            w_load = 1'b1;
            w_kind = KIND_MEM;
            w_last = (r_idx == LAST_MEM);
            w_data = mem_data_i;
        end
    end

    dump_beat_reg #(
        .W_OPR (W_OPR),
        .IW    (IW)
    ) u_beat (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_kind   (w_kind),
        .i_idx    (r_idx),
        .i_last   (w_last),
        .i_data   (w_data),
        .i_ready  (dump_ready_i),
        .o_accept (w_accept),
        .o_valid  (dump_valid_o),
        .o_kind   (w_beat_kind),
        .o_idx    (w_beat_idx),
        .o_last   (dump_last_o),
        .o_data   (dump_data_o)
    );

    assign dump_kind_o = w_beat_kind;
    assign dump_idx_o  = w_beat_idx;

    // Dump sequencer: index counter, registered read addresses and status.
    // Addresses are loaded on entry to the read state so they are already
    // stable while that state is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_reg_addr <= '0;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (hlt_i) begin
                        r_idx      <= '0;
                        r_reg_addr <= '0;
                        r_mem_req  <= 1'b1;
                        r_state    <= ST_REG_RD;
                    end
                end
                ST_REG_RD:  r_state <= ST_OUT;
                ST_MEM_RD:  r_state <= ST_MEM_LAT;
                ST_MEM_LAT: r_state <= ST_OUT;
                ST_OUT: begin
                    if (w_accept) begin
                        if (w_last_reg_beat) begin
                            r_idx      <= '0;
                            r_mem_addr <= BASE_A;
                            r_state    <= ST_MEM_RD;
                        end else if (w_last_mem_beat) begin
                            r_mem_req <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_idx <= w_idx_inc;
                            if (w_beat_kind == KIND_REG) begin
                                r_reg_addr <= RW'(w_idx_inc);
                                r_state    <= ST_REG_RD;
                            end else begin
                                r_mem_addr <= BASE_A + ADDR'(w_idx_inc);
                                r_state    <= ST_MEM_RD;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!hlt_i) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dump_unit.sv
// Directed bench for dump_unit: two instances (memory window at 0x00 and at
// 0xF8) with a combinational register-file model and a 1-cycle memory model.
module tb_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic ready;
    logic sel;
    logic hlt_a, hlt_b;

    logic [3:0]  ra_a, ra_b;
    logic [31:0] rd_a, rd_b;
    logic        mq_a, mq_b;
    logic [7:0]  ma_a, ma_b;
    logic [31:0] md_a, md_b;
    logic        v_a, v_b, k_a, k_b, l_a, l_b, d_a, d_b;
    logic [31:0] dd_a, dd_b;
    logic [15:0] ix_a, ix_b;

    assign rd_a = 32'h100 + {28'd0, ra_a};
    assign rd_b = 32'h100 + {28'd0, ra_b};
    always @(posedge clk) begin
        md_a <= 32'hA000 + {24'd0, ma_a};
        md_b <= 32'hA000 + {24'd0, ma_b};
    end

    dump_unit #(.W_OPR(32), .N_REG(16), .ADDR(8), .MEM_BASE(0), .MEM_COUNT(16), .IW(16)) dut_a (
        .clk(clk), .reset(reset), .hlt_i(hlt_a),
        .reg_addr_o(ra_a), .reg_data_i(rd_a),
        .mem_req_o(mq_a), .mem_addr_o(ma_a), .mem_data_i(md_a),
        .dump_valid_o(v_a), .dump_ready_i(ready), .dump_data_o(dd_a),
        .dump_kind_o(k_a), .dump_idx_o(ix_a), .dump_last_o(l_a), .done_o(d_a));

    dump_unit #(.W_OPR(32), .N_REG(16), .ADDR(8), .MEM_BASE(8'hF8), .MEM_COUNT(16), .IW(16)) dut_b (
        .clk(clk), .reset(reset), .hlt_i(hlt_b),
        .reg_addr_o(ra_b), .reg_data_i(rd_b),
        .mem_req_o(mq_b), .mem_addr_o(ma_b), .mem_data_i(md_b),
        .dump_valid_o(v_b), .dump_ready_i(ready), .dump_data_o(dd_b),
        .dump_kind_o(k_b), .dump_idx_o(ix_b), .dump_last_o(l_b), .done_o(d_b));

    // Observed outputs of the selected instance.
    logic        o_valid, o_kind, o_last, o_done, o_req;
    logic [31:0] o_data;
    logic [15:0] o_idx;
    logic [3:0]  o_raddr;
    logic [7:0]  o_maddr;
    assign o_valid = sel ? v_b  : v_a;
    assign o_kind  = sel ? k_b  : k_a;
    assign o_last  = sel ? l_b  : l_a;
    assign o_done  = sel ? d_b  : d_a;
    assign o_req   = sel ? mq_b : mq_a;
    assign o_data  = sel ? dd_b : dd_a;
    assign o_idx   = sel ? ix_b : ix_a;
    assign o_raddr = sel ? ra_b : ra_a;
    assign o_maddr = sel ? ma_b : ma_a;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_hlt(input logic v);
        if (sel) hlt_b = v;
        else     hlt_a = v;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".valid"}, {63'd0, o_valid}, 64'd0);
        check({tag, ".last"},  {63'd0, o_last},  64'd0);
        check({tag, ".done"},  {63'd0, o_done},  64'd0);
        check({tag, ".req"},   {63'd0, o_req},   64'd0);
        check({tag, ".kind"},  {63'd0, o_kind},  64'd0);
        check({tag, ".raddr"}, {60'd0, o_raddr}, 64'd0);
        check({tag, ".maddr"}, {56'd0, o_maddr}, 64'd0);
        check({tag, ".idx"},   {48'd0, o_idx},   64'd0);
        check({tag, ".data"},  {32'd0, o_data},  64'd0);
    endtask

    // Raises halt and follows one dump, checking every accepted beat against
    // the expected sequence and field stability across stalls.
    task automatic run_dump(input string tag, input int pct, input int base, input int drop_after,
                            input int abort_at, input int exp_done_cyc, output int nbeats);
        int k, c, first_v;
        logic pv, pr, pk, pl;
        logic [31:0] pd;
        logic [15:0] pi;
        logic [31:0] ed;
        int m;
        k = 0; first_v = 0; pv = 0; pr = 0; pk = 0; pl = 0; pd = '0; pi = '0;
        set_hlt(1'b1);
        for (c = 1; c <= 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == abort_at) break;
            if (o_done) break;
            check($sformatf("%s.req@%0d", tag, c), {63'd0, o_req}, 64'd1);
            ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (pv && !pr) begin
                check($sformatf("%s.hold_v@%0d", tag, c), {63'd0, o_valid}, 64'd1);
                check($sformatf("%s.hold_d@%0d", tag, c), {32'd0, o_data}, {32'd0, pd});
                check($sformatf("%s.hold_i@%0d", tag, c), {48'd0, o_idx}, {48'd0, pi});
                check($sformatf("%s.hold_kl@%0d", tag, c), {62'd0, o_kind, o_last}, {62'd0, pk, pl});
            end
            if (o_valid && first_v == 0) first_v = c;
            if (o_valid && ready) begin
                if (k < 16) begin
                    ed = 32'h100 + k;
                    check($sformatf("%s.b%0d", tag, k), {o_kind, o_last, o_idx, o_data},
                          {1'b0, 1'b0, 16'(k), ed});
                end else begin
                    m  = k - 16;
                    ed = 32'hA000 + ((base + m) & 8'hFF);
                    check($sformatf("%s.b%0d", tag, k), {o_kind, o_last, o_idx, o_data},
                          {1'b1, (m == 15), 16'(m), ed});
                end
                k++;
                if (k == drop_after) set_hlt(1'b0);
            end
            pv = o_valid; pr = ready; pk = o_kind; pl = o_last; pd = o_data; pi = o_idx;
        end
        nbeats = k;
        if (abort_at == 0) begin
            check({tag, ".done"}, {63'd0, o_done}, 64'd1);
            check({tag, ".nbeats"}, 64'(k), 64'd32);
            check({tag, ".req_done"}, {63'd0, o_req}, 64'd0);
            if (exp_done_cyc > 0) begin
                check({tag, ".done_cyc"}, 64'(c), 64'(exp_done_cyc));
                check({tag, ".first_v"}, 64'(first_v), 64'd2);
            end
        end
    endtask

    initial begin
        int nb;
        reset = 1'b1; ready = 1'b0; sel = 1'b0; hlt_a = 1'b0; hlt_b = 1'b0;
        tick(3);
        check_reset("rst_a");
        #2 reset = 1'b0;
        tick(2);
        check_reset("idle_a");

        // Ready tied high, then halt held after completion.
        run_dump("full", 100, 0, -1, 0, 81, nb);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check($sformatf("post.v%0d", i), {61'd0, o_valid, o_done, o_req}, 64'b010);
        end
        set_hlt(1'b0);
        tick(2);
        check("rearm.done", {62'd0, o_done, o_req}, 64'd0);

        // Random backpressure.
        run_dump("bp30", 30, 0, -1, 0, 0, nb);
        set_hlt(1'b0);
        tick(2);

        // Memory window wrapping past the top of the address space.
        sel = 1'b1;
        run_dump("wrap", 100, 8'hF8, -1, 0, 81, nb);
        set_hlt(1'b0);
        tick(2);
        sel = 1'b0;

        // Halt dropped after the third beat; dump still completes, then re-arms.
        run_dump("drop", 100, 0, 3, 0, 81, nb);
        tick(1);
        check("drop.idle", {62'd0, o_done, o_req}, 64'd0);
        run_dump("redump", 100, 0, -1, 0, 81, nb);
        set_hlt(1'b0);
        tick(2);

        // Reset during the MEM_LAT of the 20th beat.
        run_dump("pre_rst", 100, 0, -1, 43, 0, nb);
        check("pre_rst.nbeats", 64'(nb), 64'd19);
        check("pre_rst.req", {62'd0, o_req, o_valid}, 64'b10);
        #1 reset = 1'b1;
        #1 check_reset("async_rst");
        set_hlt(1'b0);
        #1 reset = 1'b0;
        tick(2);
        run_dump("restart", 100, 0, -1, 0, 81, nb);
        set_hlt(1'b0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
